// File: rtl/mem_access_ctrl.sv
// Sequences MEM-stage loads/stores onto a 64-bit data-memory port, splitting
// accesses that cross an 8-byte boundary into two beats and extending load results.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [3:0]  req_width,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_we;
    logic        r_unsigned;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [3:0]  r_width;
    logic [63:0] r_lo;
    logic [63:0] r_rdata;

    logic        w_accept;
    logic        w_beat;
    logic        w_done;
    logic [2:0]  w_off;
    logic [4:0]  w_end;
    logic        w_split;
    logic [5:0]  w_shift_lo;
    logic [6:0]  w_shift_hi;
    logic [7:0]  w_mask0;
    logic [7:0]  w_mask1;
    logic [63:0] w_merged;

    // Any width other than 1, 2 or 4 bytes is handled as a full doubleword.
    function automatic logic [3:0] norm_width(input logic [3:0] w);
        case (w)
            4'd1, 4'd2, 4'd4: return w;
            default:          return 4'd8;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] v, input logic [3:0] w,
                                           input logic uns);
        case (w)
            4'd1:    return uns ? {56'b0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
            4'd2:    return uns ? {48'b0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            4'd4:    return uns ? {32'b0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    assign w_accept   = req_valid & req_ready;
    assign w_beat     = (r_state == S_BEAT0) | (r_state == S_BEAT1);
    assign w_off      = r_addr[2:0];
    assign w_end      = {2'b00, w_off} + {1'b0, r_width};
    assign w_split    = w_end > 5'd8;
    assign w_shift_lo = {w_off, 3'b000};
    assign w_shift_hi = 7'd64 - {1'b0, w_off, 3'b000};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_mask0[i] = (5'(i) >= {2'b00, w_off}) && (5'(i) < w_end);
            w_mask1[i] = (5'(i + 8) < w_end);
        end
    end

    // Beat-0 lanes land in the low result bytes; beat-1 lanes follow them.
    assign w_merged = (r_state == S_BEAT1) ? ((r_lo >> w_shift_lo) | (mem_rdata << w_shift_hi))
                                           : (mem_rdata >> w_shift_lo);

    assign w_done = mem_ack & (((r_state == S_BEAT0) & ~w_split) | (r_state == S_BEAT1));

    always_comb begin
        // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BEAT0;
            S_BEAT0: if (mem_ack)  w_state_nxt = w_split ? S_BEAT1 : S_RESP;
            S_BEAT1: if (mem_ack)  w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_width    <= 4'd8;
            r_lo       <= '0;
            r_rdata    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we       <= req_we;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_width    <= norm_width(req_width);
            end
            if ((r_state == S_BEAT0) && mem_ack) begin
                r_lo <= mem_rdata;
            end
            if (w_done) begin
                r_rdata <= r_we ? 64'd0 : extend(w_merged, r_width, r_unsigned);
            end
        end
    end

    // Memory-side outputs decode from registered state, so reset drops them at once.
    assign mem_req    = w_beat;
    assign mem_we     = w_beat & r_we;
    assign mem_addr   = w_beat ? ({r_addr[63:3], 3'b000} + ((r_state == S_BEAT1) ? 64'd8 : 64'd0))
                               : 64'd0;
    assign mem_wmask  = (w_beat & r_we) ? ((r_state == S_BEAT1) ? w_mask1 : w_mask0) : 8'd0;
    assign mem_wdata  = (w_beat & r_we) ? ((r_state == S_BEAT1) ? (r_wdata >> w_shift_hi)
                                                                : (r_wdata << w_shift_lo))
                                        : 64'd0;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign stall      = w_beat | ((r_state == S_IDLE) & req_valid);

endmodule
